// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;
    localparam int DMEM_ADDR_W = 21;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_MASK_W = DMEM_DATA_W / 8;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    typedef enum logic {
        IDLE,
        ACCESS
    } arb_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_MASK_W-1:0] mask;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic                   lock;
    } dmem_req_t;
endpackage

// File: rtl/dmem_arb_sel.sv
// Two-requester grant selector: priority pointer, lock hold and burst limit.
// DMEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module dmem_arb_sel
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       in_access,
    input  logic       enable,
    input  logic       grant_lock,
    output logic [1:0] ready,
    output logic       pick,
    output logic       accept,
    output logic       owner
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic             lock_q;
    logic [CNT_W-1:0] burst_q;
    logic             at_limit;
    logic             force_rel;
    logic             pref;

`ifdef DMEM_ARB_RR_EN
    logic ptr_q;
    assign pref = ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PORT_CORE;
        end else if (accept && !grant_lock) begin
            ptr_q <= ~pick;
        end else if (force_rel) begin
            ptr_q <= ~owner;
        end
    end
`else
    assign pref = PORT_CORE;
`endif

    always_comb begin
        ready     = 2'b00;
        pick      = owner;
        at_limit  = (burst_q >= CNT_W'(MAX_BURST));
        // A full burst yields only when the other port is actually waiting.
        force_rel = in_access && lock_q && at_limit && valid[~owner];
        if (!in_access) begin
            pick = valid[pref] ? pref : ~pref;
            if (enable) begin
                ready[pick] = 1'b1;
            end
        end else if (lock_q && !force_rel) begin
            ready[owner] = 1'b1;
        end
        accept = valid[pick] && ready[pick];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= PORT_CORE;
            lock_q  <= 1'b0;
            burst_q <= '0;
        end else if (accept) begin
            owner  <= pick;
            lock_q <= grant_lock;
            if (!in_access) begin
                burst_q <= grant_lock ? CNT_W'(1) : '0;
            end else begin
                burst_q <= at_limit ? CNT_W'(1) : burst_q + CNT_W'(1);
            end
        end else if (in_access) begin
            lock_q  <= 1'b0;
            burst_q <= '0;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one-cycle ACCESS, response two cycles after accept.
// DMEM_ARB_RR_EN (in dmem_arb_sel) enables round-robin instead of fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p0_req_valid,
    output logic                p0_req_ready,
    input  logic                p0_req_we,
    input  logic [DATA_W/8-1:0] p0_req_mask,
    input  logic [ADDR_W-1:0]   p0_req_addr,
    input  logic [DATA_W-1:0]   p0_req_wdata,
    input  logic                p0_req_lock,
    output logic                p0_rsp_valid,
    output logic [DATA_W-1:0]   p0_rsp_rdata,
    input  logic                p1_req_valid,
    output logic                p1_req_ready,
    input  logic                p1_req_we,
    input  logic [DATA_W/8-1:0] p1_req_mask,
    input  logic [ADDR_W-1:0]   p1_req_addr,
    input  logic [DATA_W-1:0]   p1_req_wdata,
    input  logic                p1_req_lock,
    output logic                p1_rsp_valid,
    output logic [DATA_W-1:0]   p1_rsp_rdata,
    output logic                mem_cs,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_mask,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    arb_state_e            state_q, state_d;
    dmem_req_t             req0, req1, req_sel;
    logic [1:0]            ready;
    logic                  pick, accept, owner, in_access;
    logic                  ready_en_q;
    logic                  we_q;
    logic [DATA_W/8-1:0]   mask_q;

    assign req0 = '{we: p0_req_we, mask: DMEM_MASK_W'(p0_req_mask),
                    addr: DMEM_ADDR_W'(p0_req_addr), wdata: DMEM_DATA_W'(p0_req_wdata),
                    lock: p0_req_lock};
    assign req1 = '{we: p1_req_we, mask: DMEM_MASK_W'(p1_req_mask),
                    addr: DMEM_ADDR_W'(p1_req_addr), wdata: DMEM_DATA_W'(p1_req_wdata),
                    lock: p1_req_lock};
    assign req_sel   = (pick == PORT_DMA) ? req1 : req0;
    assign in_access = (state_q == ACCESS);

    dmem_arb_sel #(.MAX_BURST(MAX_BURST)) u_sel (
        .clk        (clk),
        .rst        (rst),
        .valid      ({p1_req_valid, p0_req_valid}),
        .in_access  (in_access),
        .enable     (ready_en_q),
        .grant_lock (req_sel.lock),
        .ready      (ready),
        .pick       (pick),
        .accept     (accept),
        .owner      (owner)
    );

    assign p0_req_ready = ready[PORT_CORE];
    assign p1_req_ready = ready[PORT_DMA];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // mem_cs is decoded from state so an async reset drops it at once.
    always_comb begin
        state_d  = state_q;
        mem_cs   = 1'b1;
        mem_wr   = 1'b1;
        mem_mask = '0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ACCESS;
            end
            ACCESS: begin
                mem_cs   = 1'b0;
                mem_wr   = ~we_q;
                mem_mask = mask_q;
                state_d  = accept ? ACCESS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q   <= 1'b0;
            we_q         <= 1'b0;
            mask_q       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p0_rsp_rdata <= '0;
            p1_rsp_rdata <= '0;
        end else begin
            ready_en_q   <= 1'b1;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            if (accept) begin
                we_q      <= req_sel.we;
                mask_q    <= (DATA_W/8)'(req_sel.mask);
                mem_addr  <= ADDR_W'(req_sel.addr);
                mem_wdata <= DATA_W'(req_sel.wdata);
            end
            if (in_access) begin
                if (owner == PORT_DMA) begin
                    p1_rsp_valid <= 1'b1;
                    p1_rsp_rdata <= we_q ? '0 : mem_rdata;
                end else begin
                    p0_rsp_valid <= 1'b1;
                    p0_rsp_rdata <= we_q ? '0 : mem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a memory model and response scoreboard.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req_valid, p0_req_ready, p0_req_we, p0_req_lock, p0_rsp_valid;
    logic [3:0]  p0_req_mask;
    logic [20:0] p0_req_addr;
    logic [31:0] p0_req_wdata, p0_rsp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we, p1_req_lock, p1_rsp_valid;
    logic [3:0]  p1_req_mask;
    logic [20:0] p1_req_addr;
    logic [31:0] p1_req_wdata, p1_rsp_rdata;
    logic        mem_cs, mem_wr;
    logic [3:0]  mem_mask;
    logic [20:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    typedef struct {
        logic        we;
        logic [3:0]  mask;
        logic [20:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } tb_req_t;
    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    tb_req_t     pq0[$], pq1[$];
    exp_t        sb0[$], sb1[$];
    int          glog_port[$], glog_cyc[$];
    logic [31:0] mem_arr [0:255];
    logic [31:0] ref_mem [0:255];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        acc_prev = 1'b0;
    logic        prev_we = 1'b0;
    logic [3:0]  prev_mask = 4'h0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_mask(p0_req_mask), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_req_lock(p0_req_lock), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_mask(p1_req_mask), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_req_lock(p1_req_lock), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr[7:0]];

    always @(negedge clk) begin
        if (!mem_cs && !mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) mem_arr[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_p0_ready"}, 32'(p0_req_ready), 32'd0);
        chk({tag, "_p1_ready"}, 32'(p1_req_ready), 32'd0);
        chk({tag, "_p0_rsp_valid"}, 32'(p0_rsp_valid), 32'd0);
        chk({tag, "_p1_rsp_valid"}, 32'(p1_rsp_valid), 32'd0);
        chk({tag, "_p0_rsp_rdata"}, p0_rsp_rdata, 32'd0);
        chk({tag, "_p1_rsp_rdata"}, p1_rsp_rdata, 32'd0);
        chk({tag, "_mem_cs"}, 32'(mem_cs), 32'd1);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd1);
        chk({tag, "_mem_mask"}, 32'(mem_mask), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic push(input int p, input logic we, input logic [3:0] mask,
                        input logic [20:0] addr, input logic [31:0] wdata, input logic lock);
        tb_req_t r;
        r.we = we; r.mask = mask; r.addr = addr; r.wdata = wdata; r.lock = lock;
        if (p == 0) pq0.push_back(r);
        else        pq1.push_back(r);
    endtask

    task automatic do_accept(input int p, input tb_req_t r);
        exp_t e;
        e.data = r.we ? 32'd0 : ref_mem[r.addr[7:0]];
        e.due  = cyc + 2;
        if (r.we) begin
            for (int b = 0; b < 4; b++) begin
                if (r.mask[b]) ref_mem[r.addr[7:0]][8*b +: 8] = r.wdata[8*b +: 8];
            end
        end
        if (p == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        glog_port.push_back(p);
        glog_cyc.push_back(cyc);
        prev_we   = r.we;
        prev_mask = r.mask;
    endtask

    task automatic step();
        logic  acc_now;
        logic  exp_v;
        exp_t  e;
        @(posedge clk);
        #1;
        if (pq0.size() > 0) begin
            p0_req_valid = 1'b1; p0_req_we = pq0[0].we; p0_req_mask = pq0[0].mask;
            p0_req_addr = pq0[0].addr; p0_req_wdata = pq0[0].wdata; p0_req_lock = pq0[0].lock;
        end else begin
            p0_req_valid = 1'b0;
        end
        if (pq1.size() > 0) begin
            p1_req_valid = 1'b1; p1_req_we = pq1[0].we; p1_req_mask = pq1[0].mask;
            p1_req_addr = pq1[0].addr; p1_req_wdata = pq1[0].wdata; p1_req_lock = pq1[0].lock;
        end else begin
            p1_req_valid = 1'b0;
        end
        @(negedge clk);
        cyc++;
        chk("mem_cs", 32'(mem_cs), 32'(!acc_prev));
        chk("mem_wr", 32'(mem_wr), acc_prev ? 32'(!prev_we) : 32'd1);
        chk("mem_mask", 32'(mem_mask), acc_prev ? 32'(prev_mask) : 32'd0);
        chk("ready_onehot", 32'(p0_req_ready && p1_req_ready), 32'd0);
        exp_v = (sb0.size() > 0) && (sb0[0].due == cyc);
        chk("p0_rsp_valid", 32'(p0_rsp_valid), 32'(exp_v));
        if (exp_v) begin
            e = sb0.pop_front();
            if (p0_rsp_valid) chk("p0_rsp_rdata", p0_rsp_rdata, e.data);
        end
        exp_v = (sb1.size() > 0) && (sb1[0].due == cyc);
        chk("p1_rsp_valid", 32'(p1_rsp_valid), 32'(exp_v));
        if (exp_v) begin
            e = sb1.pop_front();
            if (p1_rsp_valid) chk("p1_rsp_rdata", p1_rsp_rdata, e.data);
        end
        acc_now = 1'b0;
        if (p0_req_valid && p0_req_ready) begin
            do_accept(0, pq0.pop_front());
            acc_now = 1'b1;
        end
        if (p1_req_valid && p1_req_ready) begin
            do_accept(1, pq1.pop_front());
            acc_now = 1'b1;
        end
        acc_prev = acc_now;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((pq0.size() + pq1.size() + sb0.size() + sb1.size()) > 0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drain_done"}, 32'(pq0.size() + pq1.size() + sb0.size() + sb1.size()), 32'd0);
    endtask

    initial begin
        int          order_exp [4];
        logic [31:0] t;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        rst = 1'b1;
        p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_mask = 4'h0; p0_req_addr = '0;
        p0_req_wdata = '0; p0_req_lock = 1'b0;
        p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_mask = 4'h0; p1_req_addr = '0;
        p1_req_wdata = '0; p1_req_lock = 1'b0;

        // Reset state, with a request already pending
        repeat (2) @(posedge clk);
        #1;
        p0_req_valid = 1'b1;
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_first_cycle", 32'(p0_req_ready), 32'd0);
        p0_req_valid = 1'b0;

        // Write then readback, then byte-masked write
        push(0, 1'b1, 4'hF, 21'h10, 32'hDEADBEEF, 1'b0);
        push(0, 1'b0, 4'hF, 21'h10, 32'h0, 1'b0);
        drain("wr_rd", 40);
        chk("p0_rdata_hold", p0_rsp_rdata, 32'hDEADBEEF);
        push(0, 1'b1, 4'hF, 21'h20, 32'h11223344, 1'b0);
        push(0, 1'b1, 4'h4, 21'h20, 32'h00AB0000, 1'b0);
        push(0, 1'b0, 4'hF, 21'h20, 32'h0, 1'b0);
        drain("bytemask", 40);
        chk("bytemask_rdata", p0_rsp_rdata, 32'h11AB3344);

        // Contention, both ports valid for several accesses
        glog_port.delete(); glog_cyc.delete();
`ifdef DMEM_ARB_RR_EN
        order_exp = '{0, 1, 0, 1};
`else
        order_exp = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 4'hF, 21'h10, 32'h0, 1'b0);
            push(1, 1'b0, 4'hF, 21'h20, 32'h0, 1'b0);
        end
        drain("contend", 80);
        for (int i = 0; i < 4; i++) chk("grant_order", 32'(glog_port[i]), 32'(order_exp[i]));
        chk("p1_rdata_hold", p1_rsp_rdata, 32'h11AB3344);

        // Locked burst from p1 capped at four grants while p0 waits
        glog_port.delete(); glog_cyc.delete();
        for (int i = 0; i < 6; i++) push(1, 1'b0, 4'hF, 21'h10, 32'h0, 1'b1);
        step();
        push(0, 1'b0, 4'hF, 21'h20, 32'h0, 1'b0);
        drain("burst", 80);
        for (int i = 0; i < 4; i++) begin
            chk("burst_port", 32'(glog_port[i]), 32'd1);
            chk("burst_b2b_cycle", 32'(glog_cyc[i]), 32'(glog_cyc[0] + i));
        end
        chk("burst_release_port", 32'(glog_port[4]), 32'd0);

        // Locked owner drops valid; the other port takes the next idle cycle
        glog_port.delete(); glog_cyc.delete();
        push(0, 1'b0, 4'hF, 21'h10, 32'h0, 1'b1);
        step();
        push(1, 1'b0, 4'hF, 21'h20, 32'h0, 1'b0);
        drain("lock_drop", 40);
        chk("lock_drop_port", 32'(glog_port[1]), 32'd1);
        chk("lock_drop_cycle", 32'(glog_cyc[1]), 32'(glog_cyc[0] + 2));

        // Reset during the ACCESS of a write aborts it
        push(0, 1'b1, 4'hF, 21'h30, 32'hCAFEF00D, 1'b0);
        step();
        @(posedge clk);
        #1;
        chk("abort_in_access_cs", 32'(mem_cs), 32'd0);
        rst = 1'b1;
        p0_req_valid = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        #1;
        t = mem_arr[8'h30];
        chk("abort_no_commit", t, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_no_rsp", 32'({p1_rsp_valid, p0_rsp_valid}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb0.delete();
        ref_mem[8'h30] = 32'd0;
        acc_prev = 1'b0;
        #1;
        chk("abort_ready_first_cycle", 32'(p0_req_ready), 32'd0);
        push(0, 1'b0, 4'hF, 21'h30, 32'h0, 1'b0);
        push(0, 1'b0, 4'hF, 21'h10, 32'h0, 1'b0);
        drain("recover", 40);
        chk("recover_rdata", p0_rsp_rdata, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, 21, word address width toward data memory.
REQ-002 Parameter DATA_W, 32, data width; byte-mask width is DATA_W/8.
REQ-003 Parameter MAX_BURST, 4, maximum consecutive locked grants before a forced release.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 pN_req_valid  in  1  request from port N (N=0 core LSU, N=1 loader/DMA); same set for each port.
REQ-007 pN_req_ready  out  1  request accepted on posedge when valid&&ready.
REQ-008 pN_req_we, pN_req_mask[3:0], pN_req_addr[ADDR_W-1:0], pN_req_wdata[31:0], pN_req_lock  in  request payload; lock asks to keep the grant for the next request.
REQ-009 pN_rsp_valid  out  1  one-cycle response pulse; pN_rsp_rdata  out  32  read data, zero for writes.
REQ-010 mem_cs  out  1  chip select, active-low; mem_wr  out  1  0=write, 1=read.
REQ-011 mem_mask  out  4, mem_addr  out  ADDR_W, mem_wdata  out  32  registered access payload.
REQ-012 mem_rdata  in  32  asynchronous read data from memory.

Function
REQ-013 FSM states IDLE, ACCESS.
REQ-014 IDLE: pN_req_ready=1 only for the port the arbiter selects this cycle; the other port's ready=0.
REQ-015 On acceptance, payload is registered onto mem_* and the FSM enters ACCESS next cycle.
REQ-016 ACCESS lasts exactly one cycle with mem_cs=0 and mem_wr=~we; writes commit on that cycle's negedge.
REQ-017 At the posedge ending ACCESS, mem_rdata is captured into the owner's rsp_rdata, and rsp_valid pulses for one cycle; latency is request accept to rsp_valid = 2 cycles.
REQ-018 Outside ACCESS: mem_cs=1, mem_wr=1, mem_mask=0.
REQ-019 Unlocked throughput is one access per 2 cycles; ACCESS returns to IDLE.
REQ-020 A locked access (lock=1 at accept) keeps the owner's ready=1 during ACCESS; a back-to-back accept goes ACCESS->ACCESS.
REQ-021 A burst counter counts consecutive locked grants; at MAX_BURST, the grant is released to the other port if it has valid=1, otherwise the counter restarts at 1.
REQ-022 Both ports valid in IDLE: selection per REQ-029/030.
REQ-023 The non-owner port's rsp_valid stays 0; rsp_rdata holds its last value until the next response.
REQ-024 Owner dropping valid while locked: return to IDLE after the current ACCESS and clear the lock.

Reset
REQ-025 rst=1 forces IDLE, lock and burst counter cleared, and the priority pointer set to port 0.
REQ-026 Reset outputs: all ready=0, rsp_valid=0, rsp_rdata=0, mem_cs=1, mem_wr=1, mem_mask=0, mem_addr=0, mem_wdata=0.
REQ-027 Reset mid-ACCESS aborts the access; mem_cs deasserts immediately (async) and no response is issued.
REQ-028 ready outputs are 0 in the first cycle after rst deasserts.

Configuration
REQ-029 With DMEM_ARB_RR_EN defined: round-robin arbitration; the pointer moves to the other port after each unlocked grant or forced release.
REQ-030 Without DMEM_ARB_RR_EN: fixed priority, port 0 wins every tie.

Structure
REQ-031 Package dmem_arb_pkg holds the arb_state_e enum (IDLE, ACCESS), the dmem_req_t struct (we, mask, addr, wdata, lock) and the port index constants.
REQ-032 One sub-module, dmem_arb_sel: a two-requester selector with pointer, lock and burst-counter logic; the FSM and datapath stay in dmem_arbiter.

Verification
REQ-033 Reset, then p0 write addr=0x10, wdata=0xDEADBEEF, mask=0xF, then p0 read addr=0x10 -> p0_rsp_rdata=0xDEADBEEF 2 cycles after the read is accepted.
REQ-034 Simultaneous p0/p1 reads, both valid for 4 accesses -> without DMEM_ARB_RR_EN the grant order is 0,0,0,0; with it the order is 0,1,0,1.
REQ-035 p1 locked burst of 6 reads while p0 is valid -> p1 gets 4 back-to-back ACCESS cycles, then p0 is granted.
REQ-036 Byte write mask=0x4, wdata=0x00AB0000 over 0x11223344 -> readback 0x11AB3344.
REQ-037 rst asserted during ACCESS of a write -> mem_cs=1 the same cycle, no rsp_valid, and all outputs at REQ-026 values.
REQ-038 p0 lock=1 then valid dropped -> FSM returns to IDLE and p1 is granted on the next cycle.
